// File: rtl/inst_decoder_pkg.sv
// Shared definitions for the instruction decoder: inst bit map, phase and error-code enums.
package inst_decoder_pkg;

    localparam int INST_W = 23;
    localparam int ADDR_W = 4;
    localparam int BEAT_W = 6;

    localparam int PMEM_WR     = 0;
    localparam int PMEM_RD     = 1;
    localparam int KMEM_WR     = 2;
    localparam int KMEM_RD     = 3;
    localparam int QMEM_WR     = 4;
    localparam int QMEM_RD     = 5;
    localparam int PMEM_ADD_LO = 6;
    localparam int QMEM_ADD_LO = 10;
    localparam int OFIFO_RD    = 14;
    localparam int SFU_ACC     = 15;
    localparam int SFU_DIV     = 16;
    localparam int KMEM_ADD_LO = 17;
    localparam int RSVD_LO     = 21;
    localparam int RSVD_HI     = 22;

    typedef logic [INST_W-1:0] inst_t;

    localparam inst_t M_PW = inst_t'(1) << PMEM_WR;
    localparam inst_t M_PR = inst_t'(1) << PMEM_RD;
    localparam inst_t M_KW = inst_t'(1) << KMEM_WR;
    localparam inst_t M_KR = inst_t'(1) << KMEM_RD;
    localparam inst_t M_QW = inst_t'(1) << QMEM_WR;
    localparam inst_t M_QR = inst_t'(1) << QMEM_RD;
    localparam inst_t M_OF = inst_t'(1) << OFIFO_RD;
    localparam inst_t M_SA = inst_t'(1) << SFU_ACC;
    localparam inst_t M_SD = inst_t'(1) << SFU_DIV;
    localparam inst_t STROBE_MASK = M_PW | M_PR | M_KW | M_KR | M_QW | M_QR | M_OF | M_SA | M_SD;

    typedef enum logic [2:0] {
        PH_IDLE    = 3'd0,
        PH_KWR     = 3'd1,
        PH_KRD_QWR = 3'd2,
        PH_EXEC    = 3'd3,
        PH_SFU     = 3'd4,
        PH_DONE    = 3'd6,
        PH_ERR     = 3'd7
    } phase_t;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_RW      = 3'd1,
        ERR_RSVD    = 3'd2,
        ERR_SEQ     = 3'd3,
        ERR_ADDR    = 3'd4,
        ERR_BEAT    = 3'd5
    } err_code_t;

endpackage

// File: rtl/inst_decoder_addr_seq_checker.sv
// Address sequence checker for one memory: first access after a phase entry must hit 0,
// later accesses may repeat or advance by one (no 15->0 wrap).
module addr_seq_checker
    import inst_decoder_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              active,
    input  logic [ADDR_W-1:0] addr,
    output logic              error
);

    logic [ADDR_W-1:0] prev_q;
    logic              seen_q;
    logic              first;

    assign first = start | ~seen_q;
    assign error = active & (first ? (addr != '0)
                                   : ((addr != prev_q) &&
                                      ({1'b0, addr} != ({1'b0, prev_q} + 5'd1))));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= '0;
            seen_q <= 1'b0;
        end else if (active) begin
            prev_q <= addr;
            seen_q <= 1'b1;
        end else if (start) begin
            seen_q <= 1'b0;
        end
    end

endmodule

// File: rtl/inst_decoder.sv
// Instruction decoder: registers decoded strobes/addresses and tracks the K/Q/EXEC/SFU phase.
// Checker logic (error codes, ERR phase) is built only when INST_DECODER_CHECK_EN is defined.
module inst_decoder
    import inst_decoder_pkg::*;
#(
    parameter int col         = 8,
    parameter int total_cycle = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [INST_W-1:0] inst,
    input  logic              ctrl_done,
    output logic              k_wr,
    output logic              k_rd,
    output logic              q_wr,
    output logic              q_rd,
    output logic              p_wr,
    output logic              p_rd,
    output logic              ofifo_rd,
    output logic              sfu_acc,
    output logic              sfu_div,
    output logic [ADDR_W-1:0] k_addr,
    output logic [ADDR_W-1:0] q_addr,
    output logic [ADDR_W-1:0] p_addr,
    output logic [2:0]        phase,
    output logic [BEAT_W-1:0] beat,
    output logic              err,
    output logic [2:0]        err_code
);

    localparam logic [BEAT_W-1:0] BEAT_MAX = '1;

    phase_t            state_q, state_d, trans_to;
    logic [BEAT_W-1:0] beat_q, beat_d, beat_inc;
    inst_t             sb;
    logic              trans, qual, fire;

    assign sb = inst & STROBE_MASK;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {k_wr, k_rd, q_wr, q_rd, p_wr, p_rd, ofifo_rd, sfu_acc, sfu_div} <= '0;
            k_addr <= '0;
            q_addr <= '0;
            p_addr <= '0;
        end else begin
            k_wr     <= inst[KMEM_WR];
            k_rd     <= inst[KMEM_RD];
            q_wr     <= inst[QMEM_WR];
            q_rd     <= inst[QMEM_RD];
            p_wr     <= inst[PMEM_WR];
            p_rd     <= inst[PMEM_RD];
            ofifo_rd <= inst[OFIFO_RD];
            sfu_acc  <= inst[SFU_ACC];
            sfu_div  <= inst[SFU_DIV];
            k_addr   <= inst[KMEM_ADD_LO +: ADDR_W];
            q_addr   <= inst[QMEM_ADD_LO +: ADDR_W];
            p_addr   <= inst[PMEM_ADD_LO +: ADDR_W];
        end
    end

    // qual is the strobe that entered the current phase; holding it advances beat.
    always_comb begin
        trans    = 1'b0;
        qual     = 1'b0;
        trans_to = state_q;
        case (state_q)
            PH_IDLE: begin
                trans    = inst[KMEM_WR];
                trans_to = PH_KWR;
            end
            PH_KWR: begin
                qual     = inst[KMEM_WR];
                trans    = inst[KMEM_RD] & inst[QMEM_WR];
                trans_to = PH_KRD_QWR;
            end
            PH_KRD_QWR: begin
                qual     = inst[KMEM_RD] & inst[QMEM_WR];
                trans    = inst[QMEM_RD];
                trans_to = PH_EXEC;
            end
            PH_EXEC: begin
                qual     = inst[QMEM_RD];
                trans    = |(sb & (M_OF | M_PW));
                trans_to = PH_SFU;
            end
            PH_SFU: begin
                qual     = |(sb & (M_OF | M_PW));
                trans    = ctrl_done;
                trans_to = PH_DONE;
            end
            default: ;
        endcase
    end

    assign beat_inc = (qual && (beat_q != BEAT_MAX)) ? beat_q + BEAT_W'(1) : beat_q;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_inc;
        if (fire) begin
            state_d = PH_ERR;
            beat_d  = BEAT_W'(1);
        end else if (trans) begin
            state_d = trans_to;
            beat_d  = BEAT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= PH_IDLE;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    assign phase = state_q;
    assign beat  = beat_q;

`ifdef INST_DECODER_CHECK_EN
    logic      k_addr_err, q_addr_err, p_addr_err;
    logic      rw_err, rsvd_err, legal, beat_err, err_q;
    err_code_t code_d, code_q;

    addr_seq_checker u_k_chk (
        .clk(clk), .reset(reset), .start(trans),
        .active(inst[KMEM_WR] | inst[KMEM_RD]),
        .addr(inst[KMEM_ADD_LO +: ADDR_W]), .error(k_addr_err)
    );
    addr_seq_checker u_q_chk (
        .clk(clk), .reset(reset), .start(trans),
        .active(inst[QMEM_WR] | inst[QMEM_RD]),
        .addr(inst[QMEM_ADD_LO +: ADDR_W]), .error(q_addr_err)
    );
    addr_seq_checker u_p_chk (
        .clk(clk), .reset(reset), .start(trans),
        .active(inst[PMEM_WR] | inst[PMEM_RD]),
        .addr(inst[PMEM_ADD_LO +: ADDR_W]), .error(p_addr_err)
    );

    assign rw_err   = (inst[PMEM_WR] & inst[PMEM_RD]) | (inst[KMEM_WR] & inst[KMEM_RD]) |
                      (inst[QMEM_WR] & inst[QMEM_RD]);
    assign rsvd_err = |inst[RSVD_HI:RSVD_LO];

    // A strobe set is legal if it is a bubble, the current hold pattern, or the exit pattern.
    always_comb begin
        legal = 1'b1;
        case (state_q)
            PH_IDLE:    legal = (sb & ~M_KW) == '0;
            PH_KWR:     legal = ((sb & ~M_KW) == '0) || (sb == (M_KR | M_QW));
            PH_KRD_QWR: legal = (sb == '0) || (sb == (M_KR | M_QW)) || (sb == M_QR);
            PH_EXEC:    legal = ((sb & ~M_QR) == '0) || ((sb & ~(M_OF | M_PW)) == '0);
            PH_SFU:     legal = (sb & ~(M_OF | M_PW | M_PR | M_SA | M_SD)) == '0;
            PH_DONE:    legal = sb == '0;
            default:    legal = 1'b1;
        endcase
    end

    always_comb begin
        beat_err = 1'b0;
        case (state_q)
            PH_KWR:                      beat_err = !trans && (int'(beat_inc) > col + 1);
            PH_KRD_QWR, PH_EXEC, PH_SFU: beat_err = !trans && (int'(beat_inc) > total_cycle + 2);
            default: ;
        endcase
    end

    always_comb begin
        code_d = ERR_NONE;
        if (rw_err)                                   code_d = ERR_RW;
        else if (rsvd_err)                            code_d = ERR_RSVD;
        else if (!legal)                              code_d = ERR_SEQ;
        else if (k_addr_err | q_addr_err | p_addr_err) code_d = ERR_ADDR;
        else if (beat_err)                            code_d = ERR_BEAT;
    end

    assign fire = (code_d != ERR_NONE) && !err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q  <= 1'b0;
            code_q <= ERR_NONE;
        end else if (fire) begin
            err_q  <= 1'b1;
            code_q <= code_d;
        end
    end

    assign err      = err_q;
    assign err_code = code_q;
`else
    assign fire     = 1'b0;
    assign err      = 1'b0;
    assign err_code = '0;
`endif

endmodule

// File: tb/tb_inst_decoder.sv
// Self-checking bench for inst_decoder: directed scenarios plus randomized phase programs
// compared every cycle against a behavioural model of the decode/phase/error rules.
`timescale 1ns/1ps
module tb_inst_decoder;

    localparam int COL = 8;
    localparam int TOT = 8;
`ifdef INST_DECODER_CHECK_EN
    localparam bit CHECK = 1'b1;
`else
    localparam bit CHECK = 1'b0;
`endif

    localparam logic [22:0] S_PW  = 23'h000001;
    localparam logic [22:0] S_PR  = 23'h000002;
    localparam logic [22:0] S_KW  = 23'h000004;
    localparam logic [22:0] S_KR  = 23'h000008;
    localparam logic [22:0] S_QW  = 23'h000010;
    localparam logic [22:0] S_QR  = 23'h000020;
    localparam logic [22:0] S_OF  = 23'h004000;
    localparam logic [22:0] S_SA  = 23'h008000;
    localparam logic [22:0] S_SD  = 23'h010000;
    localparam logic [22:0] S_RSV = 23'h200000;

    logic        clk = 1'b0;
    logic        reset;
    logic [22:0] inst;
    logic        ctrl_done;
    logic        k_wr, k_rd, q_wr, q_rd, p_wr, p_rd, ofifo_rd, sfu_acc, sfu_div;
    logic [3:0]  k_addr, q_addr, p_addr;
    logic [2:0]  phase;
    logic [5:0]  beat;
    logic        err;
    logic [2:0]  err_code;

    inst_decoder #(.col(COL), .total_cycle(TOT)) dut (
        .clk(clk), .reset(reset), .inst(inst), .ctrl_done(ctrl_done),
        .k_wr(k_wr), .k_rd(k_rd), .q_wr(q_wr), .q_rd(q_rd), .p_wr(p_wr), .p_rd(p_rd),
        .ofifo_rd(ofifo_rd), .sfu_acc(sfu_acc), .sfu_div(sfu_div),
        .k_addr(k_addr), .q_addr(q_addr), .p_addr(p_addr),
        .phase(phase), .beat(beat), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    int          m_phase, m_beat, m_code;
    bit          m_err;
    int          m_prev[3];
    bit          m_seen[3];
    logic [22:0] m_last;

    task automatic model_reset();
        m_phase = 0; m_beat = 0; m_code = 0; m_err = 1'b0; m_last = '0;
        for (int m = 0; m < 3; m++) begin
            m_prev[m] = 0;
            m_seen[m] = 1'b0;
        end
    endtask

    task automatic model_step(input logic [22:0] i, input bit d);
        bit pw, pr, kw, kr, qw, qr, of, sa, sd;
        bit go, q, legal, bad_addr;
        int n, nxt, limit, nb, code;
        bit act[3];
        int adr[3];
        pw = i[0]; pr = i[1]; kw = i[2]; kr = i[3]; qw = i[4]; qr = i[5];
        of = i[14]; sa = i[15]; sd = i[16];
        n = int'(pw) + int'(pr) + int'(kw) + int'(kr) + int'(qw) + int'(qr) +
            int'(of) + int'(sa) + int'(sd);
        act[0] = kw | kr; adr[0] = int'(i[20:17]);
        act[1] = qw | qr; adr[1] = int'(i[13:10]);
        act[2] = pw | pr; adr[2] = int'(i[9:6]);
        go = 1'b0; q = 1'b0; nxt = m_phase; legal = 1'b1; limit = 1 << 20;
        case (m_phase)
            0: begin go = kw; nxt = 1; legal = (n == 0) || (n == 1 && kw); end
            1: begin
                go = kr && qw; nxt = 2; q = kw; limit = COL + 1;
                legal = (n == 0) || (n == 1 && kw) || (n == 2 && kr && qw);
            end
            2: begin
                go = qr; nxt = 3; q = kr && qw; limit = TOT + 2;
                legal = (n == 0) || (n == 2 && kr && qw) || (n == 1 && qr);
            end
            3: begin
                go = of || pw; nxt = 4; q = qr; limit = TOT + 2;
                legal = (n == 0) || (n == 1 && qr) || (n == int'(of) + int'(pw));
            end
            4: begin
                go = d; nxt = 6; q = of || pw; limit = TOT + 2;
                legal = (n == int'(pw) + int'(pr) + int'(of) + int'(sa) + int'(sd));
            end
            6: legal = (n == 0);
            default: ;
        endcase
        nb = q ? ((m_beat < 63) ? m_beat + 1 : 63) : m_beat;

        code = 0;
        if (CHECK && !m_err) begin
            bad_addr = 1'b0;
            for (int m = 0; m < 3; m++) begin
                if (act[m]) begin
                    if (go || !m_seen[m]) bad_addr |= (adr[m] != 0);
                    else bad_addr |= !(adr[m] == m_prev[m] || adr[m] == m_prev[m] + 1);
                end
            end
            if ((pw && pr) || (kw && kr) || (qw && qr)) code = 1;
            else if (i[22:21] != 2'b00)                  code = 2;
            else if (!legal)                             code = 3;
            else if (bad_addr)                           code = 4;
            else if (!go && nb > limit)                  code = 5;
        end

        for (int m = 0; m < 3; m++) begin
            if (act[m]) begin
                m_prev[m] = adr[m];
                m_seen[m] = 1'b1;
            end else if (go) begin
                m_seen[m] = 1'b0;
            end
        end

        if (code != 0) begin
            m_err = 1'b1; m_code = code; m_phase = 7; m_beat = 1;
        end else if (go) begin
            m_phase = nxt; m_beat = 1;
        end else begin
            m_beat = nb;
        end
        m_last = i;
    endtask

    task automatic compare_all(input string tag);
        logic [31:0] got_dec, exp_dec;
        got_dec = 32'({k_wr, k_rd, q_wr, q_rd, p_wr, p_rd, ofifo_rd, sfu_acc, sfu_div,
                       k_addr, q_addr, p_addr});
        exp_dec = 32'({m_last[2], m_last[3], m_last[4], m_last[5], m_last[0], m_last[1],
                       m_last[14], m_last[15], m_last[16],
                       m_last[20:17], m_last[13:10], m_last[9:6]});
        check({tag, ".decode"}, got_dec, exp_dec);
        check({tag, ".phase"}, 32'(phase), m_phase);
        check({tag, ".beat"}, 32'(beat), m_beat);
        check({tag, ".err"}, 32'(err), 32'(m_err));
        check({tag, ".err_code"}, 32'(err_code), m_code);
    endtask

    task automatic drive(input logic [22:0] i, input bit d, input string tag);
        inst = i;
        ctrl_done = d;
        @(posedge clk);
        model_step(i, d);
        @(negedge clk);
        compare_all(tag);
    endtask

    // Asserted between edges so the asynchronous clear is observed before any clock.
    task automatic pulse_reset(input string tag);
        #2 reset = 1'b1;
        model_reset();
        #1 compare_all(tag);
        inst = '0;
        ctrl_done = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [22:0] addrs(input int ka, input int qa, input int pa);
        logic [22:0] w;
        w = '0;
        w[20:17] = ka[3:0];
        w[13:10] = qa[3:0];
        w[9:6]   = pa[3:0];
        return w;
    endfunction

    function automatic int step_addr(input int a);
        int s;
        s = a + int'($urandom_range(0, 2) != 0);
        return (s > 15) ? 15 : s;
    endfunction

    task automatic rdrive(input logic [22:0] w, input bit d);
        logic [22:0] f, one;
        one = 23'd1;
        if ($urandom_range(0, 5) == 0) drive('0, 1'b0, "rnd_bubble");
        f = w;
        if ($urandom_range(0, 24) == 0) f ^= one << $urandom_range(0, 22);
        drive(f, d, "rnd");
    endtask

    task automatic run_nominal();
        for (int k = 0; k <= 8; k++) drive(S_KW | addrs(k, 0, 0), 1'b0, "nom_kwr");
        check("nom_phase_kwr", 32'(phase), 32'd1);
        for (int j = 0; j < 8; j++) drive(S_KR | S_QW | addrs(j, j, 0), 1'b0, "nom_krd_qwr");
        check("nom_phase_krd_qwr", 32'(phase), 32'd2);
        for (int j = 0; j < 8; j++) drive(S_QR | addrs(0, j, 0), 1'b0, "nom_exec");
        check("nom_phase_exec", 32'(phase), 32'd3);
        for (int j = 0; j < 8; j++) drive(S_OF | S_PW | addrs(0, 0, j), 1'b0, "nom_sfu");
        check("nom_phase_sfu", 32'(phase), 32'd4);
        check("nom_lag_paddr", 32'(p_addr), 32'd7);
        drive('0, 1'b1, "nom_done");
        check("nom_phase_done", 32'(phase), 32'd6);
        check("nom_err", 32'(err), 32'd0);
        drive('0, 1'b0, "nom_idle");
    endtask

    task automatic run_random(input int seqs);
        int kn, qn, en, sn, ka, qa, pa, kind;
        for (int s = 0; s < seqs; s++) begin
            pulse_reset("rnd_reset");
            kn = $urandom_range(1, 11); qn = $urandom_range(1, 11);
            en = $urandom_range(1, 11); sn = $urandom_range(1, 11);
            ka = 0;
            for (int b = 0; b < kn; b++) begin
                rdrive(S_KW | addrs(ka, 0, 0), 1'b0);
                ka = step_addr(ka);
            end
            ka = 0; qa = 0;
            for (int b = 0; b < qn; b++) begin
                rdrive(S_KR | S_QW | addrs(ka, qa, 0), 1'b0);
                ka = step_addr(ka); qa = step_addr(qa);
            end
            qa = 0;
            for (int b = 0; b < en; b++) begin
                rdrive(S_QR | addrs(0, qa, 0), 1'b0);
                qa = step_addr(qa);
            end
            pa = 0;
            for (int b = 0; b < sn; b++) begin
                kind = (b == 0) ? $urandom_range(0, 1) : $urandom_range(0, 3);
                case (kind)
                    0: rdrive(S_OF, 1'b0);
                    1: begin rdrive(S_PW | addrs(0, 0, pa), 1'b0); pa = step_addr(pa); end
                    2: rdrive(S_SA, 1'b0);
                    default: rdrive(S_SD, 1'b0);
                endcase
            end
            rdrive('0, 1'b1);
            rdrive('0, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        inst = '0;
        ctrl_done = 1'b0;
        model_reset();
        #1 compare_all("reset_init");
        @(negedge clk);
        reset = 1'b0;

        run_nominal();

        pulse_reset("c1_reset");
        drive(S_KW, 1'b0, "c1_enter");
        drive(23'h00000C, 1'b0, "c1_conflict");
        check("c1_err", 32'(err), 32'(CHECK));
        check("c1_code", 32'(err_code), CHECK ? 32'd1 : 32'd0);
        check("c1_phase", 32'(phase), CHECK ? 32'd7 : 32'd1);
        check("c1_strobes", 32'({k_wr, k_rd}), 32'd3);

        pulse_reset("c2_reset");
        drive(S_KW, 1'b0, "c2_enter");
        drive(S_KW | S_RSV | addrs(1, 0, 0), 1'b0, "c2_rsvd");
        check("c2_code", 32'(err_code), CHECK ? 32'd2 : 32'd0);

        pulse_reset("c4_reset");
        for (int k = 0; k <= 3; k++) drive(S_KW | addrs(k, 0, 0), 1'b0, "c4_kwr");
        drive(S_KW | addrs(5, 0, 0), 1'b0, "c4_skip");
        check("c4_code", 32'(err_code), CHECK ? 32'd4 : 32'd0);

        pulse_reset("c42_reset");
        for (int k = 0; k <= 3; k++) drive(S_KW | addrs(k, 0, 0), 1'b0, "c42_kwr");
        drive(S_KW | S_RSV | addrs(5, 0, 0), 1'b0, "c42_skip_rsvd");
        check("c42_code", 32'(err_code), CHECK ? 32'd2 : 32'd0);

        pulse_reset("c5_reset");
        for (int k = 0; k < 10; k++) drive(S_KW | addrs(k, 0, 0), 1'b0, "c5_hold");
        check("c5_code", 32'(err_code), CHECK ? 32'd5 : 32'd0);
        check("c5_beat", 32'(beat), CHECK ? 32'd1 : 32'd10);

        pulse_reset("abort_reset0");
        for (int k = 0; k <= 2; k++) drive(S_KW | addrs(k, 0, 0), 1'b0, "abort_kwr");
        for (int j = 0; j <= 2; j++) drive(S_KR | S_QW | addrs(j, j, 0), 1'b0, "abort_krd");
        check("abort_phase_before", 32'(phase), 32'd2);
        pulse_reset("abort_mid");
        check("abort_phase", 32'(phase), 32'd0);
        check("abort_err", 32'(err), 32'd0);
        drive(S_KW, 1'b0, "abort_restart");
        check("abort_restart_phase", 32'(phase), 32'd1);

        pulse_reset("wrap_reset");
        drive(S_KW, 1'b0, "wrap_k");
        drive(S_KR | S_QW, 1'b0, "wrap_kq");
        drive(S_QR, 1'b0, "wrap_q");
        drive(S_OF, 1'b0, "wrap_sfu");
        for (int a = 0; a < 16; a++) drive(S_PR | addrs(0, 0, a), 1'b0, "wrap_prd");
        drive(S_PR | addrs(0, 0, 0), 1'b0, "wrap_15_0");
        check("wrap_code", 32'(err_code), CHECK ? 32'd4 : 32'd0);

        run_random(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/inst_decoder.md
INST_DECODER -- requirements
Module: inst_decoder

Interface
REQ-001 The module SHALL have parameter col, default 8, K-phase beat count.
REQ-002 The module SHALL have parameter total_cycle, default 8, Q/exec/SFU phase beat count.
REQ-003 The module SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-004 The module SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 The module SHALL have port inst, input, 23, instruction word valid every cycle, with this bit map:
- [0] pmem_wr, [1] pmem_rd, [2] kmem_wr, [3] kmem_rd, [4] qmem_wr, [5] qmem_rd
- [9:6] pmem_add, [13:10] qmem_add, [14] ofifo_rd, [15] sfu_acc, [16] sfu_div
- [20:17] kmem_add, [22:21] reserved zero
REQ-006 The module SHALL have port ctrl_done, input, 1, done flag from the instruction source.
REQ-007 The module SHALL have outputs k_wr, k_rd, q_wr, q_rd, p_wr, p_rd, ofifo_rd, sfu_acc, sfu_div, each 1 bit: registered decoded strobes.
REQ-008 The module SHALL have outputs k_addr, q_addr, p_addr, each 4 bits: registered decoded addresses.
REQ-009 The module SHALL have output phase, 3 bits: tracked phase (0 IDLE, 1 KWR, 2 KRD_QWR, 3 EXEC, 4 SFU, 6 DONE, 7 ERR).
REQ-010 The module SHALL have output beat, 6 bits: active-strobe cycles in the current phase.
REQ-011 The module SHALL have outputs err (1 bit, sticky) and err_code (3 bits).

Function
REQ-012 All decoded strobe and address outputs SHALL equal the corresponding inst fields delayed exactly one clk.
REQ-013 Phase FSM transitions SHALL be:
- IDLE->KWR on kmem_wr
- KWR->KRD_QWR on kmem_rd&qmem_wr
- KRD_QWR->EXEC on qmem_rd
- EXEC->SFU on ofifo_rd|pmem_wr
- SFU->DONE on ctrl_done
- any phase->ERR on a checked error
REQ-014 beat SHALL clear to 1 on phase entry, increment each cycle the entry-qualifying strobe is held, and saturate at 63.
REQ-015 Error code 1: read and write of the same memory asserted in the same cycle.
REQ-016 Error code 2: inst[22:21] nonzero.
REQ-017 Error code 3: a strobe combination matching no legal transition or hold for the current phase, e.g. qmem_rd during KWR.
REQ-018 Error code 4: an address of an active memory differs from both previous+1 and previous, or is nonzero on the first active cycle; 15->0 wrap is an error.
REQ-019 Error code 5: beat exceeds col+1 in KWR, or exceeds total_cycle+2 in KRD_QWR/EXEC/SFU.
REQ-020 Only the first error SHALL be latched into err_code; when several errors occur in one cycle, the lowest code wins; err, err_code and ERR phase hold until reset.
REQ-021 Once in DONE the FSM SHALL stay in DONE; any nonzero strobe there raises code 3.

Reset
REQ-022 On reset assertion, all outputs SHALL be 0 immediately, phase SHALL be IDLE, and address history SHALL be cleared.
REQ-023 Reset asserted mid-phase SHALL abort the current phase with no error recorded; after release, tracking restarts from IDLE.

Configuration
REQ-024 The macro INST_DECODER_CHECK_EN SHALL control the checker logic.
- Defined: REQ-015..REQ-021 are implemented.
- Undefined: err and err_code are tied to 0, ERR is unreachable, and decode and phase tracking are unchanged.

Structure
REQ-025 Package inst_decoder_pkg SHALL hold the inst bit-position constants, the phase enum and the err_code enum.
REQ-026 Sub-module addr_seq_checker (inputs active, addr; output error) SHALL be instantiated three times, once each for K, Q and P.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- Nominal sequence, col=8, total_cycle=8, kmem_wr addr 0..8 etc.: phase goes 1,2,3,4,6; err=0; outputs lag inst by 1 cycle.
- inst=0x00000C (kmem_wr and kmem_rd) in KWR: err=1, err_code=1, phase=7 next cycle.
- inst[21]=1 while other fields are legal: err_code=2.
- During KWR, kmem_add steps 3->5: err_code=4; in the same cycle inject reserved bit: err_code=2.
- Hold kmem_wr for 10 cycles: err_code=5 at beat 10; assert reset in KRD_QWR: outputs 0, phase 0, err 0.
- Build without INST_DECODER_CHECK_EN and apply the REQ-015 stimulus: err stays 0, strobes are still decoded.
